// File: rtl/column_request_encoder.sv
// column_request_encoder
//   Sequential inverse of the SRAM column decoder. Per-column request strobes
//   are captured into a sticky pending register. The pending columns are
//   served one at a time in round-robin order, each as a binary column address
//   on a valid/ready handshake.
//
//   Optional feature macro: COLUMN_REQUEST_ENCODER_OVERRUN_EN
//     When defined, the block has an extra sticky `overrun` output. It flags a
//     request that arrives for a column whose earlier request is still pending.
//     When undefined, duplicate requests merge silently into the pending bit.
//
//   Handshake: addr/grant_onehot are valid while addr_valid=1. They hold
//   stable until an edge where addr_valid & addr_ready are both 1, and the
//   grant is never withdrawn before that edge.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable        permits loading a new grant (request capture is unaffected)
//   req           [NUM_COLS]   per-column request strobes
//   addr_valid    addr holds a granted column
//   addr_ready    consumer accepts addr
//   addr          [ADDR_WIDTH] granted column index
//   grant_onehot  [NUM_COLS]   one-hot copy of addr while valid, else zero
//   overrun       (optional) sticky duplicate-request flag
module column_request_encoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_COLS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_COLS-1:0]   req,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_COLS-1:0]   grant_onehot
`ifdef COLUMN_REQUEST_ENCODER_OVERRUN_EN
  ,
  output logic                  overrun
`endif
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_COLS-1:0]   pending_q, pending_d;
  logic [NUM_COLS-1:0]   clear_vec, cand, onehot_d;
  logic [ADDR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] search_start, winner, addr_next_ptr;
  logic                  found, hs, load, clear_grant;
  int                    idx;

  assign addr_valid = (state_q == S_PRESENT);
  assign hs         = addr_valid & addr_ready;

  // grant_onehot is exactly the bit being served, so it doubles as the clear mask.
  assign clear_vec = hs ? grant_onehot : '0;
  assign cand      = pending_q & ~clear_vec;

  // Set wins over clear: a column re-requested on its own handshake edge stays pending.
  assign pending_d = cand | req;

  assign addr_next_ptr = (addr == ADDR_WIDTH'(NUM_COLS - 1)) ? '0 : addr + 1'b1;

  // On a handshake edge the back-to-back search starts from the pointer value
  // that takes effect on this edge. This way the column just served goes to
  // the back of the round.
  assign search_start = hs ? addr_next_ptr : rr_ptr_q;

  // Rotating first-set search from search_start, wrapping at NUM_COLS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_COLS; i++) begin
      idx = int'(search_start) + i;
      if (idx >= NUM_COLS) idx = idx - NUM_COLS;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = ADDR_WIDTH'(idx);
      end
    end
  end

  assign onehot_d = NUM_COLS'(1) << winner;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    load        = 1'b0;
    clear_grant = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && found) begin
          load    = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (hs) begin
          rr_ptr_d = addr_next_ptr;
          if (enable && found) begin
            load = 1'b1;
          end else begin
            clear_grant = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      addr         <= '0;
      grant_onehot <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      if (load) begin
        addr         <= winner;
        grant_onehot <= onehot_d;
      end else if (clear_grant) begin
        grant_onehot <= '0;
      end
    end
  end

`ifdef COLUMN_REQUEST_ENCODER_OVERRUN_EN
  // A request hitting a bit that stays pending through this edge is a lost duplicate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (|(req & cand)) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/column_request_encoder.md
Name: column_request_encoder

Overview:
- Sequential inverse of the SRAM column decoder: accepts per-column request strobes and emits one binary column address at a time.
- Converts `NUM_COLS` request lines into an `ADDR_WIDTH`-bit address on a valid/ready handshake.
- Sits between column-side requesters (refresh / sense-complete flags) and the address path that feeds the column decoder.
- Pending requests are buffered in a sticky register and served in round-robin order.

Parameters:
- ADDR_WIDTH, 4, width of the encoded column address.
- NUM_COLS, 16, number of request lines; legal range 2 ≤ NUM_COLS ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  permits loading a new grant; does not block request capture.
- req  input  NUM_COLS  per-column request strobes, sampled every edge.
- addr_valid  output  1  `addr` holds a granted column.
- addr_ready  input  1  consumer accepts `addr`.
- addr  output  ADDR_WIDTH  encoded granted column index.
- grant_onehot  output  NUM_COLS  one-hot copy of `addr` while `addr_valid`; zero otherwise.

Behaviour:
- Reset (async assert, sync release): pending=0, rr_ptr=0, addr_valid=0, addr=0, grant_onehot=0.
- Capture: pending[i] is set on any edge where req[i]=1, regardless of enable or state.
- Arbitration:
  - Combinational search over the registered pending value.
  - Candidate set excludes the bit being cleared by a handshake on the same edge.
  - Search starts at rr_ptr and proceeds upward, wrapping from NUM_COLS-1 to 0; the first set bit wins.
- Two states:
  - IDLE: addr_valid=0. If enable=1 and pending≠0, load addr/grant_onehot with the winner and go to PRESENT.
  - PRESENT: addr_valid=1. addr and grant_onehot are held stable until handshake and are never retracted, even if enable drops.
- Handshake (addr_valid & addr_ready at an edge):
  - Clear pending[addr].
  - rr_ptr ← addr+1, wrapping to 0 past NUM_COLS-1.
  - If enable=1 and another pending bit exists, load the next winner the same edge and stay in PRESENT (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: req[i] high at edge k → pending at k → addr_valid=1 after edge k+1 (2 cycles from IDLE).
- Simultaneous set and clear of the same bit: set wins; the column re-pends and gets a later turn.
- Requests arriving on the handshake edge are not eligible for that edge's back-to-back grant; they are eligible from the next edge.
- Columns ≥ NUM_COLS never appear on addr.
- Reset mid-PRESENT drops the grant and all pending requests immediately.

Optional Feature:
- Macro: COLUMN_REQUEST_ENCODER_OVERRUN_EN.
- Defined: adds output port `overrun` (1 bit).
  - Set sticky on any edge where req[i]=1 while pending[i]=1 and pending[i] is not being cleared that edge.
  - Cleared only by reset; reset value 0.
- Undefined: port absent; duplicate requests merge silently into the pending bit.

Test Plan:
- Reset: hold rst_n=0 with random req → addr_valid=0, addr=0, grant_onehot=0. Release, req=0 for 5 cycles → outputs unchanged.
- Single request: pulse req[5] one cycle, enable=1, ready=1 → addr_valid=1 with addr=5, grant_onehot=0x0020 two edges later. Handshake once, then addr_valid=0.
- Back-pressure and round-robin:
  - Pulse req bits 0, 3, 9 together; addr_ready=0 for 4 cycles → addr stays 0.
  - Then ready=1 → grants 0, 3, 9 on consecutive cycles, no bubble.
  - Then pulse req[0] and req[12] → grant 12, then 0 (wrap from rr_ptr=10).
- enable gating: enable=0, pulse req[7] → no valid for 10 cycles. Set enable=1 → addr=7 on the next edge.
- Set/clear collision: while addr=4 valid, assert req[4] on the handshake edge → column 4 granted again after other pending columns.
- Overrun (macro defined): pulse req[2] twice before it is granted → overrun=1 and stays 1. Macro undefined: same stimulus → column 2 granted exactly once.
